// File: rtl/tgmux_pkg.sv
// Shared types and constants for the transmission-gate mux arbiter.
// State enum, select encodings and the settle-count ceiling.
package tgmux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2,
        ACK    = 2'd3
    } tgmux_arb_state_t;

    localparam logic TGMUX_SEL_D0 = 1'b0;
    localparam logic TGMUX_SEL_D1 = 1'b1;

    localparam int TGMUX_SETTLE_MAX = 15;

endpackage

// File: rtl/tgmux_settle_cnt.sv
// Loadable 4-bit down-counter with a zero flag for TG settling.
// Ports: clk, rst_n, i_load, i_load_val[3:0], i_dec, o_zero.
module tgmux_settle_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/tgmux_arbiter.sv
// Two-requester arbiter/sequencer for the 8-bit TG 2:1 mux bank.
// In: clk, rst_n, req0, req1, out_ready. Out: sel, out_valid, ack0,
// ack1, busy; gnt_cnt0/gnt_cnt1 only when TGMUX_ARB_CNT_EN is defined.
module tgmux_arbiter
    import tgmux_pkg::*;
#(
    parameter int SETTLE_CYC = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             out_ready,
    output logic             sel,
    output logic             out_valid,
    output logic             ack0,
    output logic             ack1,
`ifdef TGMUX_ARB_CNT_EN
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
`endif
    output logic             busy
);

    // Out-of-range settle values are clamped to the 4-bit counter range.
    localparam int SETTLE_CLAMP =
        (SETTLE_CYC > TGMUX_SETTLE_MAX) ? TGMUX_SETTLE_MAX :
        (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CLAMP - 1);

    tgmux_arb_state_t r_state;
    tgmux_arb_state_t w_next;

    logic r_sel;
    logic r_prio;
    logic r_win;
    logic r_out_valid;
    logic r_ack0;
    logic r_ack1;
    logic r_busy;

    logic w_tgt;
    logic w_win_req;
    logic w_load;
    logic w_dec;
    logic w_zero;

    // Contention goes to prio; otherwise whoever is asking.
    always_comb begin
        w_tgt = TGMUX_SEL_D0;
        if (req0 && req1) begin
            w_tgt = r_prio;
        end else if (req1) begin
            w_tgt = TGMUX_SEL_D1;
        end
    end

    assign w_win_req = r_win ? req1 : req0;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    if (w_tgt == r_sel) begin
                        w_next = VALID;
                    end else begin
                        w_next = SETTLE;
                        w_load = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (!w_win_req) begin
                    w_next = IDLE;
                end else if (w_zero) begin
                    w_next = VALID;
                end else begin
                    w_dec = 1'b1;
                end
            end
            VALID: begin
                if (out_ready) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    tgmux_settle_cnt u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (SETTLE_LD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Outputs are registered from the next state so nothing from the
    // inputs reaches a port combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= TGMUX_SEL_D0;
            r_prio      <= TGMUX_SEL_D0;
            r_win       <= TGMUX_SEL_D0;
            r_out_valid <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == VALID);
            r_ack0      <= (w_next == ACK) && !r_win;
            r_ack1      <= (w_next == ACK) && r_win;
            r_busy      <= (w_next != IDLE);
            if (r_state == IDLE && (req0 || req1)) begin
                r_win <= w_tgt;
            end
            if (w_load) begin
                r_sel <= w_tgt;
            end
            if (r_state == ACK) begin
                r_prio <= ~r_win;
            end
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign busy      = r_busy;

`ifdef TGMUX_ARB_CNT_EN
    logic [CNT_W-1:0] r_gnt_cnt0;
    logic [CNT_W-1:0] r_gnt_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else if (r_state == ACK) begin
            if (!r_win && !(&r_gnt_cnt0)) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
            end
            if (r_win && !(&r_gnt_cnt1)) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
            end
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_tgmux_arbiter.sv
// Self-checking bench for tgmux_arbiter: transaction-level reference
// model compared every cycle plus directed literal expectations.
module tb_tgmux_arbiter;

    localparam int SETTLE = 3;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    logic req0, req1, out_ready;
    logic sel, out_valid, ack0, ack1, busy;
`ifdef TGMUX_ARB_CNT_EN
    logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int n_chk = 0;
    int n_err = 0;

    tgmux_arbiter #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .ack0      (ack0),
        .ack1      (ack1),
`ifdef TGMUX_ARB_CNT_EN
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, tracked as
    // "busy / settle cycles left / valid / ack" rather than states.
    bit m_sel, m_prio, m_win, m_busy, m_valid, m_ack0, m_ack1;
    int m_wait;
    int m_c0, m_c1;

    always @(posedge clk or negedge rst_n) begin : model
        bit w;
        if (!rst_n) begin
            m_sel <= 0; m_prio <= 0; m_win <= 0; m_busy <= 0;
            m_valid <= 0; m_ack0 <= 0; m_ack1 <= 0; m_wait <= 0;
            m_c0 <= 0; m_c1 <= 0;
        end else if (!m_busy) begin
            if (req0 || req1) begin
                w = (req0 && req1) ? m_prio : req1;
                m_win  <= w;
                m_busy <= 1;
                if (w == m_sel) begin
                    m_valid <= 1;
                end else begin
                    m_sel  <= w;
                    m_wait <= SETTLE;
                end
            end
        end else if (m_ack0 || m_ack1) begin
            m_ack0 <= 0;
            m_ack1 <= 0;
            m_busy <= 0;
            m_prio <= !m_win;
            if (m_ack0 && m_c0 < CMAX) m_c0 <= m_c0 + 1;
            if (m_ack1 && m_c1 < CMAX) m_c1 <= m_c1 + 1;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 0;
                if (m_win) m_ack1 <= 1;
                else m_ack0 <= 1;
            end
        end else begin
            w = m_win ? req1 : req0;
            if (!w) m_busy <= 0;
            else if (m_wait == 1) m_valid <= 1;
            else m_wait <= m_wait - 1;
        end
    end

    logic p_sel, p_valid;

    always @(negedge clk) begin : compare
        if (!rst_n) begin
            p_valid = 1'b0;
            p_sel   = 1'b0;
        end else begin
            chk("sel", sel, m_sel);
            chk("out_valid", out_valid, m_valid);
            chk("ack0", ack0, m_ack0);
            chk("ack1", ack1, m_ack1);
            chk("busy", busy, m_busy);
`ifdef TGMUX_ARB_CNT_EN
            chk("gnt_cnt0", gnt_cnt0, m_c0);
            chk("gnt_cnt1", gnt_cnt1, m_c1);
`endif
            if (sel !== p_sel)
                chk("sel_while_valid", p_valid | out_valid, 0);
            p_sel   = sel;
            p_valid = out_valid;
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_sel"}, sel, 0);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_ack"}, {ack0, ack1}, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int q[$];
    int n;

    initial begin
        rst_n = 1'b1; req0 = 0; req1 = 0; out_ready = 0;
        // Reset visible before any clock edge.
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // req0 alone, same select: valid at 1, ack at 2, idle at 3.
        req0 = 1; out_ready = 1;
        @(negedge clk);
        chk("r0_valid_c1", out_valid, 1);
        chk("r0_sel_c1", sel, 0);
        @(negedge clk);
        chk("r0_ack_c2", ack0, 1);
        chk("r0_valid_c2", out_valid, 0);
        req0 = 0;
        @(negedge clk);
        chk("r0_idle_c3", busy, 0);

        // req1 alone from reset: sel at 1, valid at 4, ack at 5.
        pulse_reset();
        req1 = 1;
        @(negedge clk);
        chk("r1_sel_c1", sel, 1);
        chk("r1_valid_c1", out_valid, 0);
        repeat (2) @(negedge clk);
        chk("r1_valid_c3", out_valid, 0);
        @(negedge clk);
        chk("r1_valid_c4", out_valid, 1);
        @(negedge clk);
        chk("r1_ack_c5", ack1, 1);
        req1 = 0;
        @(negedge clk);
        chk("r1_idle", busy, 0);

        // Both held: grants alternate starting from prio=0.
        req0 = 1; req1 = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack0) q.push_back(0);
            if (ack1) q.push_back(1);
        end
        req0 = 0; req1 = 0;
        chk("alt_count_ge4", q.size() >= 4, 1);
        if (q.size() >= 4) begin
            chk("alt_g0", q[0], 0);
            chk("alt_g1", q[1], 1);
            chk("alt_g2", q[2], 0);
            chk("alt_g3", q[3], 1);
        end
        n = 0;
        while (busy && n < 12) begin @(negedge clk); n++; end
        chk("alt_drain", busy, 0);

        // Abort in SETTLE, then backpressure, then mid-VALID reset.
        pulse_reset();
        req1 = 1;
        @(negedge clk);
        chk("ab_sel", sel, 1);
        req1 = 0;
        @(negedge clk);
        chk("ab_idle", busy, 0);
        chk("ab_sel_kept", sel, 1);
        chk("ab_no_ack", ack1, 0);
        req0 = 1; req1 = 1; out_ready = 0;
        @(negedge clk);
        chk("ab_prio_kept", sel, 0);
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sel", sel, 0);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        req0 = 0; req1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_noack", {ack0, ack1}, 0);

`ifdef TGMUX_ARB_CNT_EN
        // 20 req0 grants saturate a 4-bit counter at 15.
        out_ready = 1;
        for (int g = 0; g < 20; g++) begin
            req0 = 1;
            n = 0;
            while (!ack0 && n < 10) begin @(negedge clk); n++; end
            chk("sat_ack0", ack0, 1);
            req0 = 0;
            @(negedge clk);
        end
        chk("sat_cnt0", gnt_cnt0, 15);
        chk("sat_cnt1", gnt_cnt1, 0);
        rst_n = 1'b0;
        #1 chk("rst_cnt0", gnt_cnt0, 0);
        chk("rst_cnt1", gnt_cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
